// File: rtl/n_set_cache_miss_sequencer.sv
// Sequences one cache miss: victim request, tag lookup, optional writeback, fill, tag update.
// All outputs are registered; miss and writeback statistics counters saturate at all-ones.
//
// state       | meaning
// IDLE        | waiting for a miss; captures miss address and tag
// ISSUE       | policy_miss_o pulse to the replacement policy controller
// WAIT_POL    | waiting for the victim address from the policy controller
// LOOKUP      | victim tag-store state sampled; picks writeback or fill
// WRITEBACK   | dirty victim written to memory
// FILL        | missing block fetched from memory
// UPDATE      | tag-store write of the new tag
// DONE        | miss_done_o pulse, miss counter bump
module n_set_cache_miss_sequencer #(
  parameter  int CACHE_BLOCK_CAPACITY = 128,
  parameter  int CACHE_SET_SIZE       = 4,
  parameter  int BW_TAG               = 20,
  localparam int BW_CAP               = $clog2(CACHE_BLOCK_CAPACITY),
  localparam int BW_GRP               = $clog2(CACHE_SET_SIZE),
  localparam int BW_SET               = BW_CAP - BW_GRP
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              miss_req_i,
  input  logic [BW_CAP-1:0] miss_addr_i,
  input  logic [BW_TAG-1:0] miss_tag_i,
  output logic              policy_miss_o,
  output logic [BW_CAP-1:0] policy_addr_o,
  input  logic              policy_done_i,
  input  logic [BW_CAP-1:0] policy_addr_i,
  input  logic              victim_valid_i,
  input  logic              victim_dirty_i,
  input  logic [BW_TAG-1:0] victim_tag_i,
  output logic [BW_CAP-1:0] victim_addr_o,
  output logic              mem_req_o,
  output logic              mem_rw_o,
  output logic [BW_TAG-1:0] mem_tag_o,
  output logic [BW_SET-1:0] mem_set_o,
  input  logic              mem_ack_i,
  output logic              tag_we_o,
  output logic [BW_TAG-1:0] tag_o,
  output logic              miss_done_o,
  output logic              busy_o,
  output logic [31:0]       miss_count_o,
  output logic [31:0]       wb_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_POL, S_LOOKUP, S_WRITEBACK, S_FILL, S_UPDATE, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [BW_CAP-1:0] miss_addr_q, miss_addr_d;
  logic [BW_TAG-1:0] miss_tag_q, miss_tag_d;
  logic [BW_CAP-1:0] victim_addr_q, victim_addr_d;
  logic              policy_miss_q, policy_miss_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_rw_q, mem_rw_d;
  logic [BW_TAG-1:0] mem_tag_q, mem_tag_d;
  logic [BW_SET-1:0] mem_set_q, mem_set_d;
  logic              tag_we_q, tag_we_d;
  logic              miss_done_q, miss_done_d;
  logic              busy_q, busy_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;
  logic [31:0]       wb_cnt_q, wb_cnt_d;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (miss_req_i) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_POL;
      S_WAIT_POL:  if (policy_done_i) state_d = S_LOOKUP;
      // a dirty bit on an invalid line carries no data worth saving
      S_LOOKUP:    state_d = (victim_valid_i && victim_dirty_i) ? S_WRITEBACK : S_FILL;
      S_WRITEBACK: if (mem_ack_i) state_d = S_FILL;
      S_FILL:      if (mem_ack_i) state_d = S_UPDATE;
      S_UPDATE:    state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_addr_d   = miss_addr_q;
    miss_tag_d    = miss_tag_q;
    victim_addr_d = victim_addr_q;
    mem_tag_d     = mem_tag_q;
    mem_set_d     = mem_set_q;
    miss_cnt_d    = miss_cnt_q;
    wb_cnt_d      = wb_cnt_q;

    policy_miss_d = (state_d == S_ISSUE);
    mem_req_d     = (state_d == S_WRITEBACK) || (state_d == S_FILL);
    mem_rw_d      = (state_d == S_WRITEBACK);
    tag_we_d      = (state_d == S_UPDATE);
    miss_done_d   = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);

    if (state_q == S_IDLE && miss_req_i) begin
      miss_addr_d = miss_addr_i;
      miss_tag_d  = miss_tag_i;
    end

    if (state_q == S_WAIT_POL && policy_done_i) begin
      victim_addr_d = policy_addr_i;
    end

    // mem_tag/mem_set only change on entry to a transfer so they stay stable under mem_req_o
    if (state_q == S_LOOKUP && state_d == S_WRITEBACK) begin
      mem_tag_d = victim_tag_i;
      mem_set_d = victim_addr_q[BW_SET-1:0];
    end
    if (state_q != S_FILL && state_d == S_FILL) begin
      mem_tag_d = miss_tag_q;
      mem_set_d = miss_addr_q[BW_SET-1:0];
    end

    if (state_q == S_WRITEBACK && mem_ack_i && wb_cnt_q != 32'hFFFF_FFFF) begin
      wb_cnt_d = wb_cnt_q + 32'd1;
    end
    if (state_q == S_UPDATE && miss_cnt_q != 32'hFFFF_FFFF) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      miss_addr_q   <= '0;
      miss_tag_q    <= '0;
      victim_addr_q <= '0;
      policy_miss_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_tag_q     <= '0;
      mem_set_q     <= '0;
      tag_we_q      <= 1'b0;
      miss_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      miss_cnt_q    <= '0;
      wb_cnt_q      <= '0;
    end else begin
      miss_addr_q   <= miss_addr_d;
      miss_tag_q    <= miss_tag_d;
      victim_addr_q <= victim_addr_d;
      policy_miss_q <= policy_miss_d;
      mem_req_q     <= mem_req_d;
      mem_rw_q      <= mem_rw_d;
      mem_tag_q     <= mem_tag_d;
      mem_set_q     <= mem_set_d;
      tag_we_q      <= tag_we_d;
      miss_done_q   <= miss_done_d;
      busy_q        <= busy_d;
      miss_cnt_q    <= miss_cnt_d;
      wb_cnt_q      <= wb_cnt_d;
    end
  end

  assign policy_miss_o = policy_miss_q;
  assign policy_addr_o = miss_addr_q;
  assign victim_addr_o = victim_addr_q;
  assign mem_req_o     = mem_req_q;
  assign mem_rw_o      = mem_rw_q;
  assign mem_tag_o     = mem_tag_q;
  assign mem_set_o     = mem_set_q;
  assign tag_we_o      = tag_we_q;
  assign tag_o         = miss_tag_q;
  assign miss_done_o   = miss_done_q;
  assign busy_o        = busy_q;
  assign miss_count_o  = miss_cnt_q;
  assign wb_count_o    = wb_cnt_q;

endmodule
